// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - issues n LED patterns to write_leds with programmable inter-write delay
module led_sequencer #(
    parameter int DELAY_W = 24
) (
    input  logic               __clk,
    input  logic               __reset,
    input  logic [7:0]         __p_n,
    input  logic [1:0]         __p_mode,
    input  logic [DELAY_W-1:0] __p_delay,
    input  logic               __start,
    output logic               __valid,
    output logic               __idle,
    output logic [7:0]         __retval,
    output logic [3:0]         wl_p_c,
    output logic               wl_start,
    input  logic               wl_valid,
    input  logic               wl_idle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DELAY,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           n_q, n_d;
    logic [1:0]           mode_q, mode_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [DELAY_W-1:0]   dcnt_q, dcnt_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [3:0]           pat_q, pat_d;
    logic [3:0]           k_q, k_d;
    logic                 dir_q, dir_d;

    logic [3:0]           k_nxt;
    logic [3:0]           pat_nxt;
    logic                 dir_nxt;

    always_ff @(posedge __clk) begin
        if (__reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            mode_q  <= '0;
            delay_q <= '0;
            dcnt_q  <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            k_q     <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            delay_q <= delay_d;
            dcnt_q  <= dcnt_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            k_q     <= k_d;
            dir_q   <= dir_d;
        end
    end

    // Pattern successor; dir_q=1 means the bounce is moving toward bit 3.
    always_comb begin
        k_nxt   = k_q + 4'd1;
        pat_nxt = pat_q;
        dir_nxt = dir_q;
        case (mode_q)
            2'd0: pat_nxt = k_nxt;
            2'd1: pat_nxt = {pat_q[2:0], pat_q[3]};
            2'd2: begin
                if (dir_q) begin
                    if (pat_q == 4'd8) begin
                        pat_nxt = 4'd4;
                        dir_nxt = 1'b0;
                    end else begin
                        pat_nxt = {pat_q[2:0], 1'b0};
                    end
                end else begin
                    if (pat_q == 4'd1) begin
                        pat_nxt = 4'd2;
                        dir_nxt = 1'b1;
                    end else begin
                        pat_nxt = {1'b0, pat_q[3:1]};
                    end
                end
            end
            default: pat_nxt = k_nxt ^ {1'b0, k_nxt[3:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        mode_d  = mode_q;
        delay_d = delay_q;
        dcnt_d  = dcnt_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        k_d     = k_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (__start) begin
                    n_d     = __p_n;
                    mode_d  = __p_mode;
                    delay_d = __p_delay;
                    cnt_d   = '0;
                    k_d     = '0;
                    dir_d   = 1'b1;
                    pat_d   = (__p_mode == 2'd1 || __p_mode == 2'd2) ? 4'd1 : 4'd0;
                    state_d = (__p_n == 8'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wl_idle) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (wl_valid) begin
                    cnt_d = cnt_q + 8'd1;
                    k_d   = k_nxt;
                    pat_d = pat_nxt;
                    dir_d = dir_nxt;
                    if (cnt_q + 8'd1 == n_q) begin
                        state_d = S_DONE;
                    end else if (delay_q == '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        dcnt_d  = delay_q;
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                dcnt_d = dcnt_q - DELAY_W'(1);
                if (dcnt_q == DELAY_W'(1)) state_d = S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wl_start = (state_q == S_ISSUE) && wl_idle;
    assign wl_p_c   = pat_q;
    assign __valid  = (state_q == S_DONE);
    assign __idle   = (state_q == S_IDLE);
    assign __retval = (state_q == S_DONE) ? cnt_q : 8'd0;

endmodule
